// File: rtl/pooling_output_buffer_if.sv
// Stream bundle for the pooling output buffer: tagged input results and the
// drained output stream. The buffer takes the slave side.
interface pooling_output_buffer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int FEAT_W     = 2,
    parameter int ROW_W      = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [FEAT_W-1:0]     feature_idx;
    logic [ROW_W-1:0]      feature_row;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [FEAT_W-1:0]     out_feature;
    logic                  out_last;

    modport master (
        output in_valid, feature_idx, feature_row, data_in, out_ready,
        input  in_ready, out_valid, out_data, out_feature, out_last
    );

    modport slave (
        input  in_valid, feature_idx, feature_row, data_in, out_ready,
        output in_ready, out_valid, out_data, out_feature, out_last
    );
endinterface

// File: rtl/pooling_output_buffer.sv
// Pooling output stage: keeps rows selected by stride/phase, queues them in a
// DEPTH-entry FIFO and drains them through a valid/ready stream.
module pooling_output_buffer #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_FEATURE = 4,
    parameter int ROW_W       = 3,
    parameter int POOL_STRIDE = 2,
    parameter int ROW_PHASE   = 1,
    parameter int DEPTH       = 8,
    localparam int FEAT_W     = (NUM_FEATURE > 1) ? $clog2(NUM_FEATURE) : 1,
    localparam int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    pooling_output_buffer_if.slave  bus,
    output logic [CNT_W-1:0]        level,
    output logic                    err_idx
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_data [DEPTH];
    logic [FEAT_W-1:0]     mem_feat [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;

    logic accept;
    logic row_hit;
    logic idx_ok;
    logic keep;
    logic bad_idx;
    logic pop;

    assign bus.in_ready  = (level < CNT_W'(DEPTH));
    assign bus.out_valid = (level != '0);

    assign accept  = bus.in_valid && bus.in_ready;
    assign row_hit = ((32'(bus.feature_row) % POOL_STRIDE) == ROW_PHASE);
    assign idx_ok  = (32'(bus.feature_idx) < NUM_FEATURE);
    assign keep    = accept && row_hit && idx_ok;
    assign bad_idx = accept && !idx_ok;
    assign pop     = bus.out_valid && bus.out_ready;

    // Head entry is forced to zero while empty, so reset/clear never exposes
    // stale or uninitialised storage.
    assign bus.out_data    = bus.out_valid ? mem_data[rd_ptr] : '0;
    assign bus.out_feature = bus.out_valid ? mem_feat[rd_ptr] : '0;
    assign bus.out_last    = bus.out_valid &&
                             (32'(mem_feat[rd_ptr]) == NUM_FEATURE - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            err_idx <= 1'b0;
        end else if (clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            err_idx <= 1'b0;
        end else begin
            if (keep)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({keep, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (bad_idx)
                err_idx <= 1'b1;
        end
    end

    // Storage is datapath only; occupancy and pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (keep && !clear) begin
            mem_data[wr_ptr] <= bus.data_in;
            mem_feat[wr_ptr] <= bus.feature_idx;
        end
    end
endmodule

// File: doc/pooling_output_buffer.md
# pooling_output_buffer

Parametrised output stage for the pooling layer. It accepts pooled results tagged with a feature index and feature row, and keeps only the rows selected by the pooling stride. Kept results are queued in a DEPTH-entry FIFO and drained through a valid/ready stream. It replaces the fixed four-feature, odd-row, single-register output interface with configurable width, feature count, stride and phase, backpressure, occupancy reporting and a sticky error flag.

## Interface
- DATA_WIDTH, 32, width of a pooled value (IEEE-754 single in the current design)
- NUM_FEATURE, 4, number of feature maps; FEAT_W = max(1, $clog2(NUM_FEATURE))
- ROW_W, 3, width of feature_row
- POOL_STRIDE, 2, row decimation factor; legal range 1..2^ROW_W
- ROW_PHASE, 1, a row is kept when feature_row % POOL_STRIDE == ROW_PHASE; must be < POOL_STRIDE
- DEPTH, 8, FIFO entries; power of two, ≥ 2; CNT_W = $clog2(DEPTH)+1
- clk, in, 1, clock; every flop updates on the rising edge
- rst_n, in, 1, reset, asynchronous, active-low
- clear, in, 1, synchronous flush of FIFO contents and error flag
- in_valid, in, 1, upstream result valid
- in_ready, out, 1, block can accept a result
- feature_idx, in, FEAT_W, feature map of data_in
- feature_row, in, ROW_W, pre-pooling row of data_in
- data_in, in, DATA_WIDTH, pooled value
- out_valid, out, 1, out_data is valid
- out_ready, in, 1, downstream accepts
- out_data, out, DATA_WIDTH, head-of-FIFO value
- out_feature, out, FEAT_W, feature index of the head entry
- out_last, out, 1, head entry has feature index NUM_FEATURE-1, which closes a pooled row
- level, out, CNT_W, current FIFO occupancy
- err_idx, out, 1, sticky flag: a feature_idx ≥ NUM_FEATURE was accepted

## Operation
- Accept condition: in_valid && in_ready.
- Keep condition: accept && feature_row % POOL_STRIDE == ROW_PHASE && feature_idx < NUM_FEATURE.
- Kept results write {feature_idx, data_in} at wr_ptr, then wr_ptr increments.
- An accepted result that fails the row test is consumed and dropped; it causes no write.
- An accepted result with feature_idx ≥ NUM_FEATURE is dropped and sets err_idx.
- in_ready = (level < DEPTH). It does not depend on out_ready, so there is no combinational path from out_ready to in_ready.
- Pop condition: out_valid && out_ready; rd_ptr increments.
- out_valid = (level != 0).
- out_data, out_feature and out_last are driven from the head entry. They stay stable while out_valid && !out_ready.
- Simultaneous kept write and pop: level is unchanged, and both pointers advance.
- Pointers wrap modulo DEPTH. level saturates at neither bound, because the handshake rules make overflow and underflow impossible.
- clear has priority over write and pop. When clear is high, the next cycle has rd_ptr = wr_ptr = 0, level = 0 and err_idx = 0; any input accepted in that cycle is discarded.
- Reset values: in_ready 1, out_valid 0, out_data 0, out_feature 0, out_last 0, level 0, err_idx 0; all pointers 0.
- The FIFO storage array is not reset. The outputs still read 0 after reset because the head entry is held at 0 while the FIFO is empty after reset.
- Asserting rst_n low mid-stream drops all queued entries immediately, without waiting for a clock.
- Row order is preserved; features are not reordered.

## Timing
- Latency from a kept accept at edge N to out_valid at edge N+1, with the FIFO empty: 1 cycle. There is no bypass.
- Throughput: 1 result per cycle in and 1 per cycle out with continuous ready.
- level updates one edge after each push or pop.
- When full, in_ready drops in the cycle after the DEPTH-th write. A pop in the full cycle raises in_ready on the next edge; the same cycle does not accept.
- err_idx rises on the edge after the offending accept and holds until clear or reset.

## Test plan
- Defaults, rows 0..5, features 0..3 each, values row*4+idx, continuous ready -> only rows 1, 3, 5 emerge: 12 outputs in order 4..7, 12..15, 20..23; out_last on every 4th output; first out_valid 1 cycle after the row-1 feature-0 accept.
- out_ready held 0, 10 kept results -> level reaches 8; in_ready goes 0 after the 8th write; the 9th is held upstream. Releasing out_ready drains all 10 with no loss or duplicates.
- FIFO full, then push and pop offered in the same cycle -> only the pop completes; level goes 8 -> 7; in_ready is 1 on the next cycle.
- POOL_STRIDE=3, ROW_PHASE=2, rows 0..7 -> only rows 2 and 5 are kept. Also, NUM_FEATURE=3 with feature_idx=3 -> result dropped, err_idx=1 until clear.
- 5 entries queued, clear pulsed together with in_valid -> level 0 and out_valid 0 next cycle; the concurrent input is discarded.
- Async reset mid-drain -> out_valid, level and out_data read 0 with no clock edge; normal operation resumes with rst_n high.
